// File: rtl/pbit_pkg.sv
// Shared types and constants for the p-bit update scheduler.
// The LFSR taps encode x^32+x^22+x^2+x+1 for a right-shifting Galois register.
package pbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOK = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam int IIN_W_DEF = 8;
  localparam int RND_W_DEF = 32;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/pbit_lfsr32.sv
// 32-bit Galois LFSR advanced one step per 'step' pulse.
// An all-zero seed would lock the register, so it is replaced by 1.
module pbit_lfsr32
  import pbit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] r_q;
  logic [31:0] w_seed_safe;
  logic [31:0] w_next;

  assign w_seed_safe = (seed == 32'h0) ? 32'h1 : seed;
  assign w_next      = {1'b0, r_q[31:1]} ^ (r_q[0] ? LFSR_TAPS : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= w_seed_safe;
    end else if (step) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pbit_update_sched.sv
// Round-robin scheduler sharing one external sigmoid LUT and one LFSR across N_PBIT p-bits.
// Each update walks IDLE -> LOOK -> CMP, so one p-bit is refreshed every three cycles.
module pbit_update_sched
  import pbit_pkg::*;
#(
  parameter int          N_PBIT    = 4,
  parameter int          IIN_W     = IIN_W_DEF,
  parameter int          RND_W     = RND_W_DEF,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_PBIT-1:0]       req,
  input  logic [N_PBIT*IIN_W-1:0] iin,
  output logic [N_PBIT-1:0]       ack,
  output logic [N_PBIT-1:0]       spin,
  output logic [IIN_W-1:0]        lut_iin,
  input  logic [RND_W-1:0]        lut_out,
  output logic                    busy,
  output logic [RND_W-1:0]        rnd
);

  localparam int                PTR_W = $clog2(N_PBIT);
  localparam logic [PTR_W:0]    NP    = (PTR_W + 1)'(N_PBIT);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(N_PBIT - 1);

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_g;
  logic [IIN_W-1:0]    r_lut_iin;
  logic [RND_W-1:0]    r_thr;
  logic [N_PBIT-1:0]   r_spin;
  logic [N_PBIT-1:0]   r_ack;

  logic [IIN_W-1:0]    w_iin [N_PBIT];
  logic [N_PBIT-1:0]   w_rot;
  logic [PTR_W-1:0]    w_off;
  logic                w_any;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_gnt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic                w_step;
  logic [31:0]         w_rnd;

  for (genvar k = 0; k < N_PBIT; k++) begin : g_iin
    assign w_iin[k] = iin[k*IIN_W +: IIN_W];
  end

  // Rotate requests so bit 0 is the p-bit at ptr; the lowest set bit is the winner.
  assign w_rot = N_PBIT'({req, req} >> r_ptr);

  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = N_PBIT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = PTR_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt     = (w_sum >= NP) ? PTR_W'(w_sum - NP) : PTR_W'(w_sum);
  assign w_ptr_nxt = (r_g == LAST) ? '0 : r_g + 1'b1;
  assign w_step    = (r_state == CMP);

  pbit_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_step),
    .seed  (LFSR_SEED),
    .q     (w_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_g       <= '0;
      r_lut_iin <= '0;
      r_spin    <= '0;
      r_ack     <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (en && w_any) begin
            r_g       <= w_gnt;
            r_lut_iin <= w_iin[w_gnt];
            r_state   <= LOOK;
          end
        end
        LOOK: begin
          r_state <= CMP;
        end
        CMP: begin
          r_spin[r_g] <= (rnd < r_thr);
          r_ack[r_g]  <= 1'b1;
          r_ptr       <= w_ptr_nxt;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Threshold is pure data; it is always written in LOOK before CMP reads it.
  always_ff @(posedge clk) begin
    if (r_state == LOOK) begin
      r_thr <= lut_out;
    end
  end

  assign ack     = r_ack;
  assign spin    = r_spin;
  assign lut_iin = r_lut_iin;
  assign busy    = (r_state != IDLE);
  assign rnd     = w_rnd;

endmodule

// File: tb/tb_pbit_update_sched.sv
// Scoreboard bench for pbit_update_sched with a combinational LUT stub.
// A second instance with a zero seed covers the seed guard.
module tb_pbit_update_sched;

  localparam logic [31:0] SEED = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] iin = 32'h0;
  logic        force_max = 1'b0;

  logic [3:0]  ack, spin;
  logic [7:0]  lut_iin;
  logic [31:0] lut_out, rnd;
  logic        busy;

  logic [3:0]  ack_z, spin_z;
  logic [7:0]  lut_iin_z;
  logic [31:0] rnd_z;
  logic        busy_z;
  logic        en_z = 1'b0;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  spin;
    logic [31:0] rnd;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_lfsr = SEED;
  logic [3:0]  m_spin = 4'b0;

  always #5 clk = ~clk;

  pbit_update_sched #(.N_PBIT(4), .IIN_W(8), .RND_W(32), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .iin(iin), .ack(ack), .spin(spin),
    .lut_iin(lut_iin), .lut_out(lut_out), .busy(busy), .rnd(rnd)
  );

  pbit_update_sched #(.N_PBIT(4), .IIN_W(8), .RND_W(32), .LFSR_SEED(32'h0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .en(en_z), .req(req), .iin(iin), .ack(ack_z), .spin(spin_z),
    .lut_iin(lut_iin_z), .lut_out(lut_out), .busy(busy_z), .rnd(rnd_z)
  );

  function automatic logic [31:0] stub(input logic [7:0] x, input logic fm);
    if (fm) return 32'hFFFF_FFFF;
    case (x)
      8'h7F:   return 32'h7015_336A;
      8'h80:   return 32'h0000_0000;
      default: return {~x[7], x[6:0], 24'h0};
    endcase
  endfunction

  assign lut_out = stub(lut_iin, force_max);

  // Reference for x^32+x^22+x^2+x+1: shift right, fold the output bit into those taps.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  task automatic expect_upd(input int idx, input logic [7:0] val);
    logic [31:0] thr;
    thr = stub(val, force_max);
    m_spin[idx] = (m_lfsr < thr);
    m_lfsr = ref_step(m_lfsr);
    exp_q.push_back({4'b0001 << idx, m_spin, m_lfsr});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && ack !== 4'b0) obs_q.push_back({ack, spin, rnd});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    checks++; if (spin !== 4'b0) begin errors++; $display("FAIL rst_spin got=%b exp=0000", spin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (lut_iin !== 8'h0) begin errors++; $display("FAIL rst_lut_iin got=%h exp=00", lut_iin); end
    checks++; if (rnd !== SEED) begin errors++; $display("FAIL rst_rnd got=%h exp=%h", rnd, SEED); end
    checks++; if (rnd_z !== 32'h1) begin errors++; $display("FAIL rst_zero_seed got=%h exp=00000001", rnd_z); end
    rst_n = 1'b1;
    en = 1'b1;
    tick();
  endtask

  task automatic test_single();
    expect_upd(0, 8'h7F);
    iin[7:0] = 8'h7F;
    req[0] = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b exp=1", busy); end
    checks++; if (lut_iin !== 8'h7F) begin errors++; $display("FAIL t1_lut_iin_look got=%h exp=7f", lut_iin); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL t1_ack_early1 got=%b exp=0000", ack); end
    tick();
    checks++; if (lut_iin !== 8'h7F) begin errors++; $display("FAIL t1_lut_iin_cmp got=%h exp=7f", lut_iin); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL t1_ack_early2 got=%b exp=0000", ack); end
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL t1_ack got=%b exp=0001", ack); end
    checks++; if (spin[0] !== 1'b1) begin errors++; $display("FAIL t1_spin0 got=%b exp=1", spin[0]); end
    req[0] = 1'b0;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL t1_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL t1_sb got=%h exp=%h", o, e); end
    end
    tick();
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL t1_ack_pulse got=%b exp=0000", ack); end
  endtask

  task automatic test_saturation();
    int acks, ones, exp_ones;
    logic got;
    acks = 0;
    for (int t = 0; t < 1000; t++) begin
      expect_upd(2, 8'h80);
      iin[23:16] = 8'h80;
      req[2] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (ack[2]) begin got = 1'b1; break; end
      end
      req[2] = 1'b0;
      if (got) acks++;
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t2_thr0_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e || o.spin[2] !== 1'b0) begin errors++; $display("FAIL t2_thr0_sb got=%h exp=%h", o, e); end
      end
      tick();
    end
    checks++; if (acks != 1000) begin errors++; $display("FAIL t2_ack_count got=%0d exp=1000", acks); end

    force_max = 1'b1;
    ones = 0;
    exp_ones = 0;
    for (int t = 0; t < 1000; t++) begin
      expect_upd(2, 8'h7F);
      exp_ones += int'(m_spin[2]);
      iin[23:16] = 8'h7F;
      req[2] = 1'b1;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (ack[2]) break;
      end
      req[2] = 1'b0;
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t2_thrmax_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        ones += int'(o.spin[2]);
        if (o !== e) begin errors++; $display("FAIL t2_thrmax_sb got=%h exp=%h", o, e); end
      end
      tick();
    end
    checks++; if (ones != exp_ones) begin errors++; $display("FAIL t2_ones got=%0d exp=%0d", ones, exp_ones); end
    force_max = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    rst_n = 1'b0;
    m_lfsr = SEED;
    m_spin = 4'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    iin = {8'h80, 8'h7F, 8'h90, 8'h10};
    expect_upd(0, 8'h10);
    expect_upd(1, 8'h90);
    expect_upd(2, 8'h7F);
    expect_upd(3, 8'h80);
    req = 4'b1111;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack !== 4'b0) begin
        checks++;
        if (ack !== (4'b0001 << n) || c != 3 * (n + 1)) begin
          errors++; $display("FAIL t3_order got ack=%b at edge %0d exp ack=%b at edge %0d", ack, c, 4'b0001 << n, 3 * (n + 1));
        end
        req = req & ~ack;
        n++;
        if (n == 4) break;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL t3_ack_total got=%0d exp=4", n); end
    req = 4'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t3_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL t3_sb got=%h exp=%h", o, e); end
      end
    end
    tick();
    expect_upd(0, 8'h10);
    expect_upd(3, 8'h80);
    req = 4'b1001;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack !== 4'b0) begin
        checks++;
        if (ack !== ((n == 0) ? 4'b0001 : 4'b1000)) begin
          errors++; $display("FAIL t3_wrap got=%b exp=%b", ack, (n == 0) ? 4'b0001 : 4'b1000);
        end
        req = req & ~ack;
        n++;
        if (n == 2) break;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL t3_wrap_total got=%0d exp=2", n); end
    req = 4'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t3_wrap_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL t3_wrap_sb got=%h exp=%h", o, e); end
      end
    end
    tick();
  endtask

  task automatic test_statistical();
    int ones, exp_ones;
    ones = 0;
    exp_ones = 0;
    for (int t = 0; t < 4096; t++) begin
      expect_upd(1, 8'h00);
      exp_ones += int'(m_spin[1]);
      iin[15:8] = 8'h00;
      req[1] = 1'b1;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (ack[1]) break;
      end
      req[1] = 1'b0;
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t4_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        ones += int'(o.spin[1]);
        if (o !== e) begin errors++; $display("FAIL t4_sb got=%h exp=%h", o, e); end
      end
      tick();
    end
    checks++; if (ones != exp_ones) begin errors++; $display("FAIL t4_ones_exact got=%0d exp=%0d", ones, exp_ones); end
    checks++;
    if (ones < 1925 || ones > 2171) begin errors++; $display("FAIL t4_fraction got=%0d/4096 exp=1925..2171", ones); end
    checks++; if (rnd !== m_lfsr) begin errors++; $display("FAIL t4_lfsr got=%h exp=%h", rnd, m_lfsr); end
  endtask

  task automatic test_enable();
    int hit;
    expect_upd(0, 8'h10);
    iin[7:0] = 8'h10;
    req = 4'b0001;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_look got=%b exp=1", busy); end
    en = 1'b0;
    tick();
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL t5_ack_en_low got=%b exp=0001", ack); end
    req = 4'b0010;
    iin[15:8] = 8'h7F;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL t5_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL t5_sb got=%h exp=%h", o, e); end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_busy got=%b exp=0", busy); end
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL t5_idle_ack got=%b exp=0000", ack); end
    end
    expect_upd(1, 8'h7F);
    en = 1'b1;
    hit = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (ack !== 4'b0) begin hit = c; break; end
    end
    checks++;
    if (hit != 3 || ack !== 4'b0010) begin errors++; $display("FAIL t5_resume got ack=%b at edge %0d exp ack=0010 at edge 3", ack, hit); end
    req = 4'b0;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL t5_resume_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL t5_resume_sb got=%h exp=%h", o, e); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    force_max = 1'b1;
    expect_upd(0, 8'h10);
    iin[7:0] = 8'h10;
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack[0]) break;
    end
    req = 4'b0;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL t6_pre_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL t6_pre_sb got=%h exp=%h", o, e); end
    end
    tick();
    iin[31:24] = 8'h55;
    req = 4'b1000;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (spin !== 4'b0) begin errors++; $display("FAIL t6_spin got=%b exp=0000", spin); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL t6_ack got=%b exp=0000", ack); end
    checks++; if (lut_iin !== 8'h0) begin errors++; $display("FAIL t6_lut_iin got=%h exp=00", lut_iin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got=%b exp=0", busy); end
    req = 4'b0;
    force_max = 1'b0;
    m_lfsr = SEED;
    m_spin = 4'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rnd !== SEED) begin errors++; $display("FAIL t6_rnd got=%h exp=%h", rnd, SEED); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t6_stray_ack got=%0d events exp=0", obs_q.size()); end
    iin = {8'h20, 8'h00, 8'hC0, 8'h00};
    expect_upd(1, 8'hC0);
    expect_upd(3, 8'h20);
    req = 4'b1010;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack !== 4'b0) begin
        checks++;
        if (ack !== ((n == 0) ? 4'b0010 : 4'b1000)) begin
          errors++; $display("FAIL t6_first_grant got=%b exp=%b", ack, (n == 0) ? 4'b0010 : 4'b1000);
        end
        req = req & ~ack;
        n++;
        if (n == 2) break;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL t6_ack_total got=%0d exp=2", n); end
    req = 4'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL t6_sb got=%0d events exp=%0d", obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL t6_sb got=%h exp=%h", o, e); end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_statistical();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
